// File: rtl/gen_fifo_ctrl_mch_top.sv
// gen_fifo_ctrl_mch_top
// Multi-channel FIFO controller. CH_N logical FIFOs share one single-write,
// single-read memory. Each channel has a run-time base address and depth.
// The block tracks per-channel pointers and occupancy and drives the shared
// memory write and read addresses.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cfg_base          per-channel base address   [c*ADDR_W +: ADDR_W]
//   cfg_size          per-channel depth (0 = off) [c*CNT_W +: CNT_W]
//   cfg_af_th/ae_th   almost-full (>=) / almost-empty (<=) thresholds
//   clr               per-channel clear; it wins over push/pop to that channel
//   push/push_ch      write request and target channel
//   pop/pop_ch        read request and target channel
//   wr_en/wr_addr     memory write strobe/address (combinational)
//   rd_en/rd_addr     memory read strobe/address (combinational)
//   sts_*             per-channel occupancy and status (from registered count)
//   err_ovfl/udfl     rejected push/pop this cycle
//   err_sticky        per-channel sticky error flag
module gen_fifo_ctrl_mch_top #(
    parameter  int unsigned CH_N   = 4,
    parameter  int unsigned PTR_W  = 4,
    localparam int unsigned CH_W   = $clog2(CH_N),
    localparam int unsigned CNT_W  = PTR_W + 1,
    localparam int unsigned ADDR_W = PTR_W + CH_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CH_N*ADDR_W-1:0]  cfg_base,
    input  logic [CH_N*CNT_W-1:0]   cfg_size,
    input  logic [CH_N*CNT_W-1:0]   cfg_af_th,
    input  logic [CH_N*CNT_W-1:0]   cfg_ae_th,
    input  logic [CH_N-1:0]         clr,
    input  logic                    push,
    input  logic [CH_W-1:0]         push_ch,
    input  logic                    pop,
    input  logic [CH_W-1:0]         pop_ch,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       rd_addr,
    output logic [CH_N*CNT_W-1:0]   sts_count,
    output logic [CH_N-1:0]         sts_full,
    output logic [CH_N-1:0]         sts_af,
    output logic [CH_N-1:0]         sts_ae,
    output logic [CH_N-1:0]         sts_empty,
    output logic                    err_ovfl,
    output logic                    err_udfl,
    output logic [CH_N-1:0]         err_sticky
);

    // Per-channel state
    logic [PTR_W-1:0] wr_ptr_q [CH_N];
    logic [PTR_W-1:0] wr_ptr_d [CH_N];
    logic [PTR_W-1:0] rd_ptr_q [CH_N];
    logic [PTR_W-1:0] rd_ptr_d [CH_N];
    logic [CNT_W-1:0] count_q  [CH_N];
    logic [CNT_W-1:0] count_d  [CH_N];
    logic [CH_N-1:0]  err_sticky_q;
    logic [CH_N-1:0]  err_sticky_d;

    // Unpacked configuration
    logic [ADDR_W-1:0] base_c  [CH_N];
    logic [CNT_W-1:0]  size_c  [CH_N];
    logic [CNT_W-1:0]  af_th_c [CH_N];
    logic [CNT_W-1:0]  ae_th_c [CH_N];

    // Selected-channel views for the push and pop ports
    logic              push_full_c;
    logic              pop_empty_c;
    logic [ADDR_W-1:0] wr_base_c;
    logic [ADDR_W-1:0] rd_base_c;
    logic [PTR_W-1:0]  wr_ptr_sel_c;
    logic [PTR_W-1:0]  rd_ptr_sel_c;
    logic              push_acc_c;
    logic              pop_acc_c;
    logic [CH_N-1:0]   push_hit_c;
    logic [CH_N-1:0]   pop_hit_c;
    logic [CH_N-1:0]   ovfl_hit_c;
    logic [CH_N-1:0]   udfl_hit_c;

    // Advance a pointer, wrapping after size-1; compare at CNT_W so a full
    // 2^PTR_W depth wraps from all-ones to zero.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p,
                                                 input logic [CNT_W-1:0] sz);
        if (CNT_W'(p) == (sz - CNT_W'(1))) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Configuration unpack
    always_comb begin
        for (int c = 0; c < int'(CH_N); c++) begin
            base_c[c]  = cfg_base[c*ADDR_W +: ADDR_W];
            size_c[c]  = cfg_size[c*CNT_W +: CNT_W];
            af_th_c[c] = cfg_af_th[c*CNT_W +: CNT_W];
            ae_th_c[c] = cfg_ae_th[c*CNT_W +: CNT_W];
        end
    end

    // Status from registered occupancy; a size-0 channel reads full and empty
    always_comb begin
        sts_count = '0;
        sts_full  = '0;
        sts_af    = '0;
        sts_ae    = '0;
        sts_empty = '0;
        for (int c = 0; c < int'(CH_N); c++) begin
            sts_count[c*CNT_W +: CNT_W] = count_q[c];
            sts_full[c]  = (count_q[c] == size_c[c]);
            sts_empty[c] = (count_q[c] == '0);
            sts_af[c]    = (count_q[c] >= af_th_c[c]);
            sts_ae[c]    = (count_q[c] <= ae_th_c[c]);
        end
    end

    // Channel select; an index beyond CH_N-1 looks full and empty
    always_comb begin
        push_full_c  = 1'b1;
        pop_empty_c  = 1'b1;
        wr_base_c    = '0;
        rd_base_c    = '0;
        wr_ptr_sel_c = '0;
        rd_ptr_sel_c = '0;
        for (int c = 0; c < int'(CH_N); c++) begin
            if (push_ch == CH_W'(c)) begin
                push_full_c  = sts_full[c];
                wr_base_c    = base_c[c];
                wr_ptr_sel_c = wr_ptr_q[c];
            end
            if (pop_ch == CH_W'(c)) begin
                pop_empty_c  = sts_empty[c];
                rd_base_c    = base_c[c];
                rd_ptr_sel_c = rd_ptr_q[c];
            end
        end
    end

    // Acceptance uses current status only; no same-cycle push/pop bypass
    always_comb begin
        push_acc_c = push & ~push_full_c;
        pop_acc_c  = pop & ~pop_empty_c;
        wr_en      = push_acc_c;
        rd_en      = pop_acc_c;
        err_ovfl   = push & push_full_c;
        err_udfl   = pop & pop_empty_c;
        wr_addr    = wr_base_c + ADDR_W'(wr_ptr_sel_c);
        rd_addr    = rd_base_c + ADDR_W'(rd_ptr_sel_c);
        err_sticky = err_sticky_q;
    end

    // Per-channel decode of this cycle's events
    always_comb begin
        push_hit_c = '0;
        pop_hit_c  = '0;
        ovfl_hit_c = '0;
        udfl_hit_c = '0;
        for (int c = 0; c < int'(CH_N); c++) begin
            push_hit_c[c] = push_acc_c & (push_ch == CH_W'(c));
            pop_hit_c[c]  = pop_acc_c  & (pop_ch  == CH_W'(c));
            ovfl_hit_c[c] = err_ovfl   & (push_ch == CH_W'(c));
            udfl_hit_c[c] = err_udfl   & (pop_ch  == CH_W'(c));
        end
    end

    // Next-state: clr dominates; count holds when push and pop both land
    always_comb begin
        err_sticky_d = err_sticky_q;
        for (int c = 0; c < int'(CH_N); c++) begin
            wr_ptr_d[c] = wr_ptr_q[c];
            rd_ptr_d[c] = rd_ptr_q[c];
            count_d[c]  = count_q[c];
            if (clr[c]) begin
                wr_ptr_d[c]     = '0;
                rd_ptr_d[c]     = '0;
                count_d[c]      = '0;
                err_sticky_d[c] = 1'b0;
            end else begin
                if (push_hit_c[c]) begin
                    wr_ptr_d[c] = ptr_inc(wr_ptr_q[c], size_c[c]);
                end
                if (pop_hit_c[c]) begin
                    rd_ptr_d[c] = ptr_inc(rd_ptr_q[c], size_c[c]);
                end
                case ({push_hit_c[c], pop_hit_c[c]})
                    2'b10:   count_d[c] = count_q[c] + CNT_W'(1);
                    2'b01:   count_d[c] = count_q[c] - CNT_W'(1);
                    default: count_d[c] = count_q[c];
                endcase
                if (ovfl_hit_c[c] || udfl_hit_c[c]) begin
                    err_sticky_d[c] = 1'b1;
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky_q <= '0;
            for (int c = 0; c < int'(CH_N); c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                count_q[c]  <= '0;
            end
        end else begin
            err_sticky_q <= err_sticky_d;
            for (int c = 0; c < int'(CH_N); c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                count_q[c]  <= count_d[c];
            end
        end
    end

endmodule

// File: tb/tb_gen_fifo_ctrl_mch_top.sv
// Testbench for gen_fifo_ctrl_mch_top: directed scenarios plus a randomized
// run, all compared against a per-channel occupancy/pointer model.
module tb_gen_fifo_ctrl_mch_top;

    localparam int CH_N   = 4;
    localparam int PTR_W  = 4;
    localparam int CH_W   = 2;
    localparam int CNT_W  = PTR_W + 1;
    localparam int ADDR_W = PTR_W + CH_W;
    localparam int AMOD   = 1 << ADDR_W;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [CH_N*ADDR_W-1:0] cfg_base;
    logic [CH_N*CNT_W-1:0]  cfg_size;
    logic [CH_N*CNT_W-1:0]  cfg_af_th;
    logic [CH_N*CNT_W-1:0]  cfg_ae_th;
    logic [CH_N-1:0]        clr;
    logic                   push;
    logic [CH_W-1:0]        push_ch;
    logic                   pop;
    logic [CH_W-1:0]        pop_ch;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic                   rd_en;
    logic [ADDR_W-1:0]      rd_addr;
    logic [CH_N*CNT_W-1:0]  sts_count;
    logic [CH_N-1:0]        sts_full;
    logic [CH_N-1:0]        sts_af;
    logic [CH_N-1:0]        sts_ae;
    logic [CH_N-1:0]        sts_empty;
    logic                   err_ovfl;
    logic                   err_udfl;
    logic [CH_N-1:0]        err_sticky;

    int checks = 0;
    int errors = 0;

    // Configuration and reference model state
    int size [CH_N];
    int base [CH_N];
    int afth [CH_N];
    int aeth [CH_N];
    int m_wp [CH_N];
    int m_rp [CH_N];
    int m_cnt[CH_N];
    bit m_err[CH_N];

    gen_fifo_ctrl_mch_top #(.CH_N(CH_N), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_base(cfg_base), .cfg_size(cfg_size),
        .cfg_af_th(cfg_af_th), .cfg_ae_th(cfg_ae_th),
        .clr(clr), .push(push), .push_ch(push_ch), .pop(pop), .pop_ch(pop_ch),
        .wr_en(wr_en), .wr_addr(wr_addr), .rd_en(rd_en), .rd_addr(rd_addr),
        .sts_count(sts_count), .sts_full(sts_full), .sts_af(sts_af),
        .sts_ae(sts_ae), .sts_empty(sts_empty),
        .err_ovfl(err_ovfl), .err_udfl(err_udfl), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int c = 0; c < CH_N; c++) begin
            cfg_base[c*ADDR_W +: ADDR_W] = ADDR_W'(base[c]);
            cfg_size[c*CNT_W +: CNT_W]   = CNT_W'(size[c]);
            cfg_af_th[c*CNT_W +: CNT_W]  = CNT_W'(afth[c]);
            cfg_ae_th[c*CNT_W +: CNT_W]  = CNT_W'(aeth[c]);
        end
    end

    function automatic bit mfull(input int c);
        return m_cnt[c] == size[c];
    endfunction

    function automatic bit mempty(input int c);
        return m_cnt[c] == 0;
    endfunction

    function automatic int cnt_of(input int c);
        return int'(sts_count[c*CNT_W +: CNT_W]);
    endfunction

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        int pc = int'(push_ch);
        int qc = int'(pop_ch);
        bit pa = push && !mfull(pc);
        bit qa = pop && !mempty(qc);
        bit ov = push && mfull(pc);
        bit ud = pop && mempty(qc);
        for (int c = 0; c < CH_N; c++) begin
            if (rst || clr[c]) begin
                m_wp[c] = 0; m_rp[c] = 0; m_cnt[c] = 0; m_err[c] = 0;
            end else begin
                if (pa && pc == c) begin
                    m_wp[c] = (m_wp[c] + 1) % size[c];
                    m_cnt[c]++;
                end
                if (qa && qc == c) begin
                    m_rp[c] = (m_rp[c] + 1) % size[c];
                    m_cnt[c]--;
                end
                if ((ov && pc == c) || (ud && qc == c)) m_err[c] = 1;
            end
        end
    endtask

    task automatic drive(input bit ps, input int pc, input bit pp, input int qc,
                         input logic [CH_N-1:0] cl);
        push = ps; push_ch = CH_W'(pc); pop = pp; pop_ch = CH_W'(qc); clr = cl;
        #1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        size = '{4, 8, 16, 2};
        base = '{0, 4, 12, 28};
        afth = '{3, 6, 12, 2};
        aeth = '{1, 1, 2, 0};
        rst = 1'b1;
        drive(1, 0, 1, 1, '1);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, '0);
        checks++; if (sts_count !== '0) begin errors++; $display("FAIL reset_count got %h exp 0", sts_count); end
        checks++; if (sts_empty !== 4'hF) begin errors++; $display("FAIL reset_empty got %b exp 1111", sts_empty); end
        checks++; if (sts_full !== 4'h0) begin errors++; $display("FAIL reset_full got %b exp 0000", sts_full); end
        checks++; if (err_sticky !== 4'h0) begin errors++; $display("FAIL reset_sticky got %b exp 0000", err_sticky); end
        checks++; if ({wr_en, rd_en, err_ovfl, err_udfl} !== 4'b0) begin errors++; $display("FAIL reset_strobes got %b exp 0000", {wr_en, rd_en, err_ovfl, err_udfl}); end
    endtask

    task automatic test_fill_ch0();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, '0);
            checks++; if (wr_en !== 1'b1 || wr_addr !== ADDR_W'(i)) begin errors++; $display("FAIL fill_wr got en=%b addr=%0d exp en=1 addr=%0d", wr_en, wr_addr, i); end
            tick();
        end
        drive(0, 0, 0, 0, '0);
        checks++; if (sts_full[0] !== 1'b1 || cnt_of(0) != 4) begin errors++; $display("FAIL fill_full got full=%b cnt=%0d exp 1/4", sts_full[0], cnt_of(0)); end
        checks++; if (sts_af[0] !== 1'b1) begin errors++; $display("FAIL fill_af got %b exp 1", sts_af[0]); end
        drive(1, 0, 0, 0, '0);
        checks++; if (err_ovfl !== 1'b1 || wr_en !== 1'b0) begin errors++; $display("FAIL fill_ovfl got ovfl=%b wr_en=%b exp 1/0", err_ovfl, wr_en); end
        tick();
        drive(0, 0, 0, 0, '0);
        checks++; if (err_sticky[0] !== 1'b1) begin errors++; $display("FAIL fill_sticky got %b exp 1", err_sticky[0]); end
    endtask

    task automatic test_ch3_interleave();
        for (int i = 0; i < 5; i++) begin
            drive(1, 3, 0, 3, '0);
            checks++; if (wr_addr !== ADDR_W'(28 + i % 2)) begin errors++; $display("FAIL ch3_wr got %0d exp %0d", wr_addr, 28 + i % 2); end
            tick();
            drive(0, 3, 1, 3, '0);
            checks++; if (rd_en !== 1'b1 || rd_addr !== ADDR_W'(28 + i % 2)) begin errors++; $display("FAIL ch3_rd got en=%b addr=%0d exp 1/%0d", rd_en, rd_addr, 28 + i % 2); end
            tick();
            checks++; if (cnt_of(3) > 2) begin errors++; $display("FAIL ch3_cnt got %0d exp <=2", cnt_of(3)); end
        end
    endtask

    task automatic test_simul_pushpop();
        for (int i = 0; i < 3; i++) begin drive(1, 1, 0, 1, '0); tick(); end
        drive(1, 1, 1, 1, '0);
        checks++; if ({wr_en, rd_en} !== 2'b11 || wr_addr !== 6'd7 || rd_addr !== 6'd4) begin errors++; $display("FAIL simul3_addr got en=%b%b wr=%0d rd=%0d exp 11/7/4", wr_en, rd_en, wr_addr, rd_addr); end
        tick();
        drive(0, 1, 0, 1, '0);
        checks++; if (cnt_of(1) != 3) begin errors++; $display("FAIL simul3_cnt got %0d exp 3", cnt_of(1)); end
        checks++; if (wr_addr !== 6'd8 || rd_addr !== 6'd5) begin errors++; $display("FAIL simul3_ptrs got wr=%0d rd=%0d exp 8/5", wr_addr, rd_addr); end
        for (int i = 0; i < 3; i++) begin drive(0, 1, 1, 1, '0); tick(); end
        drive(1, 1, 1, 1, '0);
        checks++; if ({wr_en, rd_en, err_udfl} !== 3'b101) begin errors++; $display("FAIL simul0_strobes got %b exp 101", {wr_en, rd_en, err_udfl}); end
        tick();
        drive(0, 1, 0, 1, '0);
        checks++; if (cnt_of(1) != 1) begin errors++; $display("FAIL simul0_cnt got %0d exp 1", cnt_of(1)); end
    endtask

    task automatic test_full_pushpop();
        drive(1, 0, 1, 0, '0);
        checks++; if ({err_ovfl, wr_en, rd_en} !== 3'b101 || rd_addr !== 6'd0) begin errors++; $display("FAIL fullpp got ovfl/wr/rd=%b rd=%0d exp 101/0", {err_ovfl, wr_en, rd_en}, rd_addr); end
        tick();
        drive(0, 0, 0, 0, '0);
        checks++; if (cnt_of(0) != 3) begin errors++; $display("FAIL fullpp_cnt got %0d exp 3", cnt_of(0)); end
    endtask

    task automatic test_cross_clr();
        drive(1, 1, 1, 2, '0);
        checks++; if ({wr_en, err_udfl} !== 2'b11) begin errors++; $display("FAIL cross_strobes got %b exp 11", {wr_en, err_udfl}); end
        tick();
        drive(0, 0, 0, 0, '0);
        checks++; if (cnt_of(1) != 2 || err_sticky[2] !== 1'b1) begin errors++; $display("FAIL cross_state got cnt1=%0d st2=%b exp 2/1", cnt_of(1), err_sticky[2]); end
        drive(0, 0, 0, 0, 4'b0100);
        tick();
        drive(0, 0, 0, 0, '0);
        checks++; if (err_sticky[2] !== 1'b0 || err_sticky[1] !== 1'b1 || cnt_of(1) != 2) begin errors++; $display("FAIL clr2 got st=%b cnt1=%0d exp st2=0 st1=1 cnt1=2", err_sticky, cnt_of(1)); end
        drive(1, 0, 0, 0, 4'b0001);
        checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL clr0_wren got %b exp 1", wr_en); end
        tick();
        drive(0, 0, 0, 0, '0);
        checks++; if (cnt_of(0) != 0 || err_sticky[0] !== 1'b0) begin errors++; $display("FAIL clr0_state got cnt=%0d st=%b exp 0/0", cnt_of(0), err_sticky[0]); end
    endtask

    task automatic test_wrap16();
        for (int i = 0; i < 16; i++) begin
            drive(1, 2, 0, 2, '0);
            checks++; if (wr_en !== 1'b1 || wr_addr !== ADDR_W'(12 + i)) begin errors++; $display("FAIL wrap_wr got en=%b addr=%0d exp 1/%0d", wr_en, wr_addr, 12 + i); end
            tick();
        end
        drive(0, 2, 0, 2, '0);
        checks++; if (sts_full[2] !== 1'b1 || cnt_of(2) != 16 || wr_addr !== 6'd12) begin errors++; $display("FAIL wrap_full got full=%b cnt=%0d wr=%0d exp 1/16/12", sts_full[2], cnt_of(2), wr_addr); end
        for (int i = 0; i < 16; i++) begin
            drive(0, 2, 1, 2, '0);
            checks++; if (rd_en !== 1'b1 || rd_addr !== ADDR_W'(12 + i)) begin errors++; $display("FAIL wrap_rd got en=%b addr=%0d exp 1/%0d", rd_en, rd_addr, 12 + i); end
            tick();
        end
        drive(0, 2, 0, 2, '0);
        checks++; if (sts_empty[2] !== 1'b1 || rd_addr !== 6'd12) begin errors++; $display("FAIL wrap_empty got empty=%b rd=%0d exp 1/12", sts_empty[2], rd_addr); end
    endtask

    task automatic test_disabled();
        size[3] = 0;
        drive(0, 3, 0, 3, '0);
        checks++; if (sts_full[3] !== 1'b1 || sts_empty[3] !== 1'b1) begin errors++; $display("FAIL dis_sts got full=%b empty=%b exp 1/1", sts_full[3], sts_empty[3]); end
        drive(1, 3, 0, 3, '0);
        checks++; if ({err_ovfl, wr_en} !== 2'b10) begin errors++; $display("FAIL dis_push got ovfl/wr=%b exp 10", {err_ovfl, wr_en}); end
        tick();
        drive(0, 3, 1, 3, '0);
        checks++; if ({err_udfl, rd_en} !== 2'b10) begin errors++; $display("FAIL dis_pop got udfl/rd=%b exp 10", {err_udfl, rd_en}); end
        tick();
        size[3] = 2;
        drive(0, 0, 0, 0, 4'b1000);
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            logic [CH_N-1:0] cl = '0;
            int pc = int'($urandom % CH_N);
            int qc = int'($urandom % CH_N);
            bit ps = ($urandom % 8) < 5;
            bit pp = ($urandom % 8) < 4;
            int ec;
            for (int c = 0; c < CH_N; c++) cl[c] = ($urandom % 64) == 0;
            if (n % 64 == 63) begin
                ec = int'($urandom % CH_N);
                cl[ec] = 1'b1;
                size[ec] = int'($urandom_range(0, 16));
                base[ec] = int'($urandom % AMOD);
                afth[ec] = int'($urandom_range(0, 16));
                aeth[ec] = int'($urandom_range(0, 16));
            end
            drive(ps, pc, pp, qc, cl);
            checks++; if (wr_en !== (ps && !mfull(pc)) || err_ovfl !== (ps && mfull(pc))) begin errors++; $display("FAIL rnd_push n=%0d got wr=%b ov=%b exp wr=%b ov=%b", n, wr_en, err_ovfl, ps && !mfull(pc), ps && mfull(pc)); end
            checks++; if (rd_en !== (pp && !mempty(qc)) || err_udfl !== (pp && mempty(qc))) begin errors++; $display("FAIL rnd_pop n=%0d got rd=%b ud=%b exp rd=%b ud=%b", n, rd_en, err_udfl, pp && !mempty(qc), pp && mempty(qc)); end
            checks++; if (wr_addr !== ADDR_W'((base[pc] + m_wp[pc]) % AMOD)) begin errors++; $display("FAIL rnd_wr_addr n=%0d got %0d exp %0d", n, wr_addr, (base[pc] + m_wp[pc]) % AMOD); end
            checks++; if (rd_addr !== ADDR_W'((base[qc] + m_rp[qc]) % AMOD)) begin errors++; $display("FAIL rnd_rd_addr n=%0d got %0d exp %0d", n, rd_addr, (base[qc] + m_rp[qc]) % AMOD); end
            for (int c = 0; c < CH_N; c++) begin
                checks++;
                if (cnt_of(c) != m_cnt[c] || sts_full[c] !== mfull(c) || sts_empty[c] !== mempty(c)
                    || sts_af[c] !== (m_cnt[c] >= afth[c]) || sts_ae[c] !== (m_cnt[c] <= aeth[c])
                    || err_sticky[c] !== m_err[c]) begin
                    errors++;
                    $display("FAIL rnd_ch n=%0d ch=%0d got cnt=%0d f/af/ae/e/st=%b%b%b%b%b exp cnt=%0d f/af/ae/e/st=%b%b%b%b%b",
                             n, c, cnt_of(c), sts_full[c], sts_af[c], sts_ae[c], sts_empty[c], err_sticky[c],
                             m_cnt[c], mfull(c), m_cnt[c] >= afth[c], m_cnt[c] <= aeth[c], mempty(c), m_err[c]);
                end
            end
            tick();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clr = '0; push = 1'b0; pop = 1'b0; push_ch = '0; pop_ch = '0;
        test_reset();
        test_fill_ch0();
        test_ch3_interleave();
        test_simul_pushpop();
        test_full_pushpop();
        test_cross_clr();
        test_wrap16();
        test_disabled();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gen_fifo_ctrl_mch_top.md
# gen_fifo_ctrl_mch_top

Multi-channel FIFO controller: manages CH_N independent logical FIFOs carved out of one shared single-write/single-read memory. Each channel has a run-time base address and depth. The block tracks per-channel read/write pointers and occupancy, and drives the shared memory's write and read addresses. It sits between multi-stream producers/consumers and a single `gen_mem`-style RAM, and is the multi-channel successor of the configurable-size FIFO control.

## Interface
Parameters:
- CH_N, 4: number of logical channels (≥2).
- PTR_W, 4: per-channel pointer width; max channel depth is 2^PTR_W.
- CH_W, $clog2(CH_N): channel index width (localparam).
- CNT_W, PTR_W+1: count/size/threshold width (localparam).
- ADDR_W, PTR_W+CH_W: shared memory address width (localparam).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cfg_base  in  CH_N*ADDR_W  per-channel base address, channel c at bits [c*ADDR_W +: ADDR_W].
- cfg_size  in  CH_N*CNT_W  per-channel depth, 0 = channel disabled.
- cfg_af_th  in  CH_N*CNT_W  almost-full threshold (count ≥ th).
- cfg_ae_th  in  CH_N*CNT_W  almost-empty threshold (count ≤ th).
- clr  in  CH_N  per-channel clear.
- push  in  1  write request.
- push_ch  in  CH_W  channel targeted by push.
- pop  in  1  read request.
- pop_ch  in  CH_W  channel targeted by pop.
- wr_en  out  1  memory write enable (accepted push).
- wr_addr  out  ADDR_W  memory write address.
- rd_en  out  1  memory read enable (accepted pop).
- rd_addr  out  ADDR_W  memory read address.
- sts_count  out  CH_N*CNT_W  per-channel occupancy.
- sts_full, sts_af, sts_ae, sts_empty  out  CH_N each  per-channel status.
- err_ovfl, err_udfl  out  1 each  rejected push / rejected pop this cycle.
- err_sticky  out  CH_N  per-channel sticky error flag (any ovfl/udfl).

## Operation
- Per channel c: wr_ptr[c], rd_ptr[c] (PTR_W), count[c] (CNT_W), err_sticky[c]; all registered.
- sts_full[c] = (count==cfg_size[c]); sts_empty[c] = (count==0); sts_af/sts_ae use the thresholds. All are combinational from registered count. A disabled channel (size 0) reads full=1 and empty=1.
- Push accepted iff push & ~sts_full[push_ch]; pop accepted iff pop & ~sts_empty[pop_ch]. Acceptance uses the current-cycle status only. A same-cycle pop does not free space for a push, and a same-cycle push does not fill an empty channel for a pop.
- wr_addr = cfg_base[push_ch] + wr_ptr[push_ch], truncated to ADDR_W (modulo 2^ADDR_W). rd_addr is the same using rd_ptr[pop_ch]. Both are combinational and valid every cycle, regardless of push/pop.
- On accept, the pointer advances by 1 and wraps to 0 after cfg_size[c]-1. The wrap compare uses full CNT_W width, so size = 2^PTR_W wraps from all-ones to 0.
- count: +1 on accepted push only, −1 on accepted pop only, unchanged when both are accepted on the same channel. Push and pop on different channels each update their own channel.
- err_ovfl = push & sts_full[push_ch]; err_udfl = pop & sts_empty[pop_ch]. Each sets err_sticky of the addressed channel.
- clr[c] zeroes wr_ptr, rd_ptr, count and err_sticky of channel c and has priority over any push/pop to c that cycle. That push/pop still reports through wr_en/rd_en: wr_en is not masked, but the write is discarded.
- cfg_* may change only while the affected channel is empty or under clr. Otherwise behaviour is undefined, with no checking required. Overlapping channel regions are a software error and are not detected.

## Timing
- Reset (rst=1 at clk edge): all pointers, counts and err_sticky become 0. Hence sts_count=0, sts_empty=all 1, sts_full=1 only for channels with size 0. wr_en/rd_en/err_* follow inputs combinationally and are 0 when push/pop=0. rst overrides clr and push/pop.
- wr_en and wr_addr are valid in the push cycle; the memory writes at the same edge the controller updates.
- rd_en and rd_addr are valid in the pop cycle. Data latency is the memory's; the controller adds none.
- Status reflects an accepted push/pop one cycle later.

## Test plan
- Reset, then cfg CH_N=4, size={4,8,16,2}, base={0,4,12,28}. Push 4 to ch0 → wr_addr 0,1,2,3; sts_full[0]=1 next cycle. A 5th push → err_ovfl=1, wr_en=0, err_sticky[0]=1.
- ch3 (size 2, base 28): push/pop interleaved 5 times → wr_addr/rd_addr alternate 28,29,28… and count stays ≤2.
- Same-channel simultaneous push+pop on ch1 with count=3 → count stays 3 and both pointers advance. Same test at count=0 → push accepted, err_udfl=1, count→1.
- Full ch0 plus pop ch0 and push ch0 in the same cycle → push rejected (err_ovfl), pop accepted, count 4→3.
- Push to ch1 while popping ch2 with ch2 empty → ch1 count +1, err_udfl=1, err_sticky[2]=1. Then clr[2] alone → err_sticky[2]=0, ch1 untouched.
- Size 16 on ch2: 16 pushes then 16 pops → pointers wrap 15→0, rd_addr sequence 12..27, empty at end. cfg_size=0 channel → push gives err_ovfl, pop gives err_udfl.
